d_unit: RTL and testbench

// - Decode stage: consumes IRD/PC4D from the fetch unit; returns NPC, PCsrc, Branch, RS_D_OUT to it.
// - Holds the 32x32 GPR file (written by W stage), resolves branch/jump in D, and owns the D/E pipeline register.
// - Bubble insertion on stall is done here, so the hazard unit only drives PauseD.

---
 rtl/d_unit_pkg.sv | 46 ++++
 rtl/d_unit_if.sv | 37 +++
 rtl/d_unit_grf_d.sv | 54 +++++
 rtl/d_unit.sv | 115 +++++++++++
 tb/tb_d_unit.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/d_unit_pkg.sv
// Shared decode-stage definitions: opcodes, PC source and forwarding codes,
// D/E register layout and the immediate extender.
package d_unit_pkg;

   localparam int unsigned XLEN = 32;

   localparam logic [5:0] OP_SPECIAL = 6'b000000;
   localparam logic [5:0] OP_J       = 6'b000010;
   localparam logic [5:0] OP_JAL     = 6'b000011;
   localparam logic [5:0] OP_BEQ     = 6'b000100;
   localparam logic [5:0] OP_BNE     = 6'b000101;
   localparam logic [5:0] OP_ANDI    = 6'b001100;
   localparam logic [5:0] OP_ORI     = 6'b001101;
   localparam logic [5:0] OP_LUI     = 6'b001111;
   localparam logic [5:0] FN_JR      = 6'b001000;

   typedef enum logic [1:0] {
      PC_ADD4 = 2'b00,
      PC_NPC  = 2'b01,
      PC_JR   = 2'b10
   } pc_src_e;

   typedef enum logic [1:0] {
      FWD_GRF = 2'b00,
      FWD_E   = 2'b01,
      FWD_M   = 2'b10
   } fwd_sel_e;

   typedef struct packed {
      logic [XLEN-1:0] ir;
      logic [XLEN-1:0] pc4;
      logic [XLEN-1:0] rs;
      logic [XLEN-1:0] rt;
      logic [XLEN-1:0] ext;
   } de_reg_t;

   // lui places imm in the upper half; logical immediates are zero-extended.
   function automatic logic [XLEN-1:0] ext_imm(input logic [5:0] op, input logic [15:0] imm);
      case (op)
         OP_LUI:          ext_imm = {imm, 16'h0000};
         OP_ORI, OP_ANDI: ext_imm = {16'h0000, imm};
         default:         ext_imm = {{16{imm[15]}}, imm};
      endcase
   endfunction

endpackage

// File: rtl/d_unit_if.sv
// Fetch/W-stage/hazard side bundle of the decode stage; the D/E register
// outputs ride on the same bundle.
interface d_unit_if;

   logic [31:0] IRD;
   logic [31:0] PC4D;
   logic        PauseD;
   logic        RegWriteW;
   logic [4:0]  WAddrW;
   logic [31:0] WDataW;
   logic [1:0]  FwdRSD;
   logic [1:0]  FwdRTD;
   logic [31:0] FwdDataE;
   logic [31:0] FwdDataM;
   logic [31:0] NPC;
   logic [1:0]  PCsrc;
   logic        Branch;
   logic [31:0] RS_D_OUT;
   logic [31:0] IRE;
   logic [31:0] PC4E;
   logic [31:0] RS_E;
   logic [31:0] RT_E;
   logic [31:0] EXT_E;

   modport master (
      output IRD, PC4D, PauseD, RegWriteW, WAddrW, WDataW,
             FwdRSD, FwdRTD, FwdDataE, FwdDataM,
      input  NPC, PCsrc, Branch, RS_D_OUT, IRE, PC4E, RS_E, RT_E, EXT_E
   );

   modport slave (
      input  IRD, PC4D, PauseD, RegWriteW, WAddrW, WDataW,
             FwdRSD, FwdRTD, FwdDataE, FwdDataM,
      output NPC, PCsrc, Branch, RS_D_OUT, IRE, PC4E, RS_E, RT_E, EXT_E
   );

endinterface

// File: rtl/d_unit_grf_d.sv
// General-purpose register file: two combinational read ports with
// write-through bypass, one synchronous write port, $0 fixed at zero.
module grf_d
   import d_unit_pkg::*;
#(
   parameter int unsigned RF_DEPTH = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            we,
   input  logic [4:0]      waddr,
   input  logic [XLEN-1:0] wdata,
   input  logic [4:0]      raddr1,
   input  logic [4:0]      raddr2,
   output logic [XLEN-1:0] rdata1,
   output logic [XLEN-1:0] rdata2
);

   logic [XLEN-1:0] regs_q [RF_DEPTH];
   logic [XLEN-1:0] regs_d [RF_DEPTH];
   logic            wr_en;

   assign wr_en = we && (waddr != 5'd0);

   always_comb begin
      regs_d = regs_q;
      if (wr_en) begin
         regs_d[waddr] = wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < RF_DEPTH; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         regs_q <= regs_d;
      end
   end

   // A write landing this cycle is visible to a same-cycle read of that address.
   always_comb begin
      rdata1 = '0;
      rdata2 = '0;
      if (raddr1 != 5'd0) begin
         rdata1 = (wr_en && (waddr == raddr1)) ? wdata : regs_q[raddr1];
      end
      if (raddr2 != 5'd0) begin
         rdata2 = (wr_en && (waddr == raddr2)) ? wdata : regs_q[raddr2];
      end
   end

endmodule

// File: rtl/d_unit.sv
// Decode stage: GPR read with forwarding, immediate extension, branch/jump
// resolution and the D/E pipeline register with bubble insertion on stall.
module d_unit
   import d_unit_pkg::*;
#(
   parameter int unsigned RF_DEPTH  = 32,
   parameter logic [31:0] RESET_PC4 = 32'h0000_0000
) (
   input  logic     Clk,
   input  logic     Reset,
   d_unit_if.slave  bus
);

   logic [5:0]      op;
   logic [5:0]      funct;
   logic [4:0]      rs_addr;
   logic [4:0]      rt_addr;
   logic [15:0]     imm;
   logic [XLEN-1:0] grf_rs;
   logic [XLEN-1:0] grf_rt;
   logic [XLEN-1:0] rs_val;
   logic [XLEN-1:0] rt_val;
   logic [XLEN-1:0] ext_val;
   logic [XLEN-1:0] npc;
   logic            branch;
   pc_src_e         pc_src;
   de_reg_t         de_d;
   de_reg_t         de_q;

   assign op      = bus.IRD[31:26];
   assign funct   = bus.IRD[5:0];
   assign rs_addr = bus.IRD[25:21];
   assign rt_addr = bus.IRD[20:16];
   assign imm     = bus.IRD[15:0];

   grf_d #(
      .RF_DEPTH (RF_DEPTH)
   ) u_grf (
      .clk    (Clk),
      .rst_n  (Reset),
      .we     (bus.RegWriteW),
      .waddr  (bus.WAddrW),
      .wdata  (bus.WDataW),
      .raddr1 (rs_addr),
      .raddr2 (rt_addr),
      .rdata1 (grf_rs),
      .rdata2 (grf_rt)
   );

   // Unused select code 11 falls back to the register file.
   always_comb begin
      case (bus.FwdRSD)
         FWD_E:   rs_val = bus.FwdDataE;
         FWD_M:   rs_val = bus.FwdDataM;
         default: rs_val = grf_rs;
      endcase
      case (bus.FwdRTD)
         FWD_E:   rt_val = bus.FwdDataE;
         FWD_M:   rt_val = bus.FwdDataM;
         default: rt_val = grf_rt;
      endcase
   end

   assign ext_val = ext_imm(op, imm);

   always_comb begin
      branch = 1'b0;
      pc_src = PC_ADD4;
      npc    = bus.PC4D;
      case (op)
         OP_BEQ, OP_BNE: begin
            branch = (op == OP_BEQ) ? (rs_val == rt_val) : (rs_val != rt_val);
            pc_src = branch ? PC_NPC : PC_ADD4;
            npc    = bus.PC4D + {{14{imm[15]}}, imm, 2'b00};
         end
         OP_J, OP_JAL: begin
            pc_src = PC_NPC;
            npc    = {bus.PC4D[31:28], bus.IRD[25:0], 2'b00};
         end
         OP_SPECIAL: begin
            if (funct == FN_JR) begin
               pc_src = PC_JR;
            end
         end
         default: ;
      endcase
   end

   assign bus.NPC      = npc;
   assign bus.PCsrc    = pc_src;
   assign bus.Branch   = branch;
   assign bus.RS_D_OUT = rs_val;

   always_comb begin
      de_d = '{ir: bus.IRD, pc4: bus.PC4D, rs: rs_val, rt: rt_val, ext: ext_val};
      if (bus.PauseD) begin
         de_d = '{ir: '0, pc4: RESET_PC4, rs: '0, rt: '0, ext: '0};
      end
   end

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         de_q <= '{ir: '0, pc4: RESET_PC4, rs: '0, rt: '0, ext: '0};
      end else begin
         de_q <= de_d;
      end
   end

   assign bus.IRE   = de_q.ir;
   assign bus.PC4E  = de_q.pc4;
   assign bus.RS_E  = de_q.rs;
   assign bus.RT_E  = de_q.rt;
   assign bus.EXT_E = de_q.ext;

endmodule

// File: tb/tb_d_unit.sv
// Self-checking bench for d_unit: directed scenarios followed by randomized
// instruction/forwarding/stall traffic against a behavioural decode model.
module tb_d_unit;

   localparam logic [31:0] RST_PC4 = 32'h0000_3000;

   logic Clk = 1'b0;
   logic Reset;
   always #5 Clk = ~Clk;

   d_unit_if bus ();

   d_unit #(
      .RF_DEPTH  (32),
      .RESET_PC4 (RST_PC4)
   ) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus)
   );

   int n_chk  = 0;
   int n_fail = 0;

   logic [31:0] m_gpr [32];
   logic [31:0] m_ire, m_pc4e, m_rse, m_rte, m_exte;
   logic [31:0] e_rs, e_rt, e_ext;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] enc_i(input int op, input int rs, input int rt, input logic [15:0] imm);
      enc_i = (32'(op) << 26) | (32'(rs) << 21) | (32'(rt) << 16) | {16'h0, imm};
   endfunction

   function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input int fn);
      enc_r = (32'(rs) << 21) | (32'(rt) << 16) | (32'(rd) << 11) | 32'(fn);
   endfunction

   function automatic logic [31:0] enc_j(input int op, input logic [25:0] tgt);
      enc_j = (32'(op) << 26) | {6'h0, tgt};
   endfunction

   // Register value as seen by decode this cycle, including a pending W write.
   function automatic logic [31:0] m_read(input int a);
      if (a == 0) return 32'h0;
      if (bus.RegWriteW && int'(bus.WAddrW) == a) return bus.WDataW;
      return m_gpr[a];
   endfunction

   function automatic logic [31:0] m_fwd(input logic [1:0] sel, input int a);
      if (sel == 2'd1) return bus.FwdDataE;
      if (sel == 2'd2) return bus.FwdDataM;
      return m_read(a);
   endfunction

   function automatic logic [31:0] m_ext(input int op, input logic [15:0] imm);
      int s;
      if (op == 15) return 32'(imm) * 32'd65536;
      if (op == 13 || op == 12) return 32'(imm);
      s = int'($signed(imm));
      return 32'(s);
   endfunction

   task automatic comb_check();
      int op, fn;
      logic [31:0] ir, pc4, npc;
      logic [1:0]  pcs;
      logic        br;
      #2;
      ir  = bus.IRD;
      pc4 = bus.PC4D;
      op  = int'(ir >> 26);
      fn  = int'(ir & 32'h3F);
      e_rs  = m_fwd(bus.FwdRSD, int'((ir >> 21) & 32'h1F));
      e_rt  = m_fwd(bus.FwdRTD, int'((ir >> 16) & 32'h1F));
      e_ext = m_ext(op, ir[15:0]);
      br = 1'b0; pcs = 2'd0; npc = pc4;
      if (op == 4 || op == 5) begin
         br  = (op == 4) ? (e_rs == e_rt) : (e_rs != e_rt);
         pcs = br ? 2'd1 : 2'd0;
         npc = pc4 + e_ext * 32'd4;
      end else if (op == 2 || op == 3) begin
         pcs = 2'd1;
         npc = (pc4 & 32'hF000_0000) + (ir & 32'h03FF_FFFF) * 32'd4;
      end else if (op == 0 && fn == 8) begin
         pcs = 2'd2;
      end
      check("NPC", bus.NPC, npc);
      check("PCsrc", 32'(bus.PCsrc), 32'(pcs));
      check("Branch", 32'(bus.Branch), 32'(br));
      check("RS_D_OUT", bus.RS_D_OUT, e_rs);
   endtask

   task automatic clk_check();
      @(posedge Clk);
      if (!Reset) begin
         for (int i = 0; i < 32; i++) m_gpr[i] = 32'h0;
         {m_ire, m_rse, m_rte, m_exte} = '0;
         m_pc4e = RST_PC4;
      end else begin
         if (bus.PauseD) begin
            {m_ire, m_rse, m_rte, m_exte} = '0;
            m_pc4e = RST_PC4;
         end else begin
            m_ire = bus.IRD; m_pc4e = bus.PC4D;
            m_rse = e_rs; m_rte = e_rt; m_exte = e_ext;
         end
         if (bus.RegWriteW && bus.WAddrW != 5'd0) m_gpr[bus.WAddrW] = bus.WDataW;
      end
      #1;
      check("IRE", bus.IRE, m_ire);
      check("PC4E", bus.PC4E, m_pc4e);
      check("RS_E", bus.RS_E, m_rse);
      check("RT_E", bus.RT_E, m_rte);
      check("EXT_E", bus.EXT_E, m_exte);
   endtask

   task automatic idle_inputs();
      bus.IRD = 32'h0; bus.PC4D = 32'h0; bus.PauseD = 1'b0;
      bus.RegWriteW = 1'b0; bus.WAddrW = 5'd0; bus.WDataW = 32'h0;
      bus.FwdRSD = 2'd0; bus.FwdRTD = 2'd0; bus.FwdDataE = 32'h0; bus.FwdDataM = 32'h0;
   endtask

   task automatic wr_reg(input int a, input logic [31:0] d);
      idle_inputs();
      bus.RegWriteW = 1'b1; bus.WAddrW = 5'(a); bus.WDataW = d;
      comb_check(); clk_check();
   endtask

   int ops [10] = '{0, 2, 3, 4, 5, 9, 12, 13, 15, 35};

   initial begin
      Reset = 1'b0;
      idle_inputs();
      for (int i = 0; i < 32; i++) m_gpr[i] = 32'h0;

      // reset for two cycles; register file is unknown before the first edge
      clk_check();
      bus.IRD = enc_r(5, 0, 0, 33);
      comb_check();
      check("rd_r5_reset", bus.RS_D_OUT, 32'h0);
      clk_check();
      check("PC4E_reset", bus.PC4E, RST_PC4);
      Reset = 1'b1;

      // write-through bypass into rs
      idle_inputs();
      bus.RegWriteW = 1'b1; bus.WAddrW = 5'd8; bus.WDataW = 32'h1234;
      bus.IRD = enc_r(8, 0, 9, 33);
      comb_check();
      check("bypass", bus.RS_D_OUT, 32'h1234);
      clk_check();
      check("bypass_RS_E", bus.RS_E, 32'h1234);

      // beq taken, backward offset
      wr_reg(1, 32'd7);
      wr_reg(2, 32'd7);
      idle_inputs();
      bus.IRD = enc_i(4, 1, 2, 16'hFFFF); bus.PC4D = 32'h3004;
      comb_check();
      check("beq_Branch", 32'(bus.Branch), 32'd1);
      check("beq_NPC", bus.NPC, 32'h3000);
      clk_check();

      // jal and jr through E forwarding
      idle_inputs();
      bus.IRD = enc_j(3, 26'h0C01); bus.PC4D = 32'h3008;
      comb_check();
      check("jal_NPC", bus.NPC, 32'h0000_3004);
      clk_check();
      idle_inputs();
      bus.IRD = enc_r(31, 0, 0, 8); bus.FwdRSD = 2'd1; bus.FwdDataE = 32'h3010;
      comb_check();
      check("jr_PCsrc", 32'(bus.PCsrc), 32'd2);
      check("jr_target", bus.RS_D_OUT, 32'h3010);
      clk_check();

      // stall inserts a bubble, release loads the held instruction
      idle_inputs();
      bus.IRD = enc_i(35, 1, 3, 16'h0010); bus.PC4D = 32'h3020; bus.PauseD = 1'b1;
      comb_check(); clk_check();
      check("pause_IRE", bus.IRE, 32'h0);
      bus.PauseD = 1'b0;
      comb_check(); clk_check();
      check("release_IRE", bus.IRE, enc_i(35, 1, 3, 16'h0010));

      // $0 is not writable; lui extension
      idle_inputs();
      bus.RegWriteW = 1'b1; bus.WAddrW = 5'd0; bus.WDataW = 32'hFFFF_FFFF;
      bus.IRD = enc_r(0, 0, 4, 33);
      comb_check();
      check("r0_bypass", bus.RS_D_OUT, 32'h0);
      clk_check();
      idle_inputs();
      bus.IRD = enc_i(15, 0, 5, 16'h8000);
      comb_check();
      check("r0_stored", bus.RS_D_OUT, 32'h0);
      clk_check();
      check("lui_EXT_E", bus.EXT_E, 32'h8000_0000);

      // randomized traffic; small register range makes rs==rt and bypass hits common
      for (int n = 0; n < 600; n++) begin
         int op;
         op = ops[$urandom_range(0, 9)];
         Reset = ($urandom_range(0, 49) != 0);
         bus.PauseD = ($urandom_range(0, 4) == 0);
         bus.RegWriteW = $urandom_range(0, 1) == 1;
         bus.WAddrW = 5'($urandom_range(0, 7));
         bus.WDataW = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 3));
         bus.FwdRSD = 2'($urandom_range(0, 3));
         bus.FwdRTD = 2'($urandom_range(0, 3));
         bus.FwdDataE = 32'($urandom_range(0, 3));
         bus.FwdDataM = $urandom;
         bus.PC4D = $urandom & 32'hFFFF_FFFC;
         if (op == 2 || op == 3) begin
            bus.IRD = enc_j(op, 26'($urandom));
         end else if (op == 0) begin
            bus.IRD = enc_r($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                            ($urandom_range(0, 2) == 0) ? 8 : 33);
         end else begin
            bus.IRD = enc_i(op, $urandom_range(0, 7), $urandom_range(0, 7), 16'($urandom));
         end
         comb_check();
         clk_check();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
